// File: rtl/decode_stage.sv
// RV32I decode stage: register file, operand build and a registered ALU issue bundle.
// Define DECODE_WB_BYPASS_EN to forward same-edge writeback data into the operands.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            CK_REF,
  input  logic            RST_N,
  input  logic [31:0]     INSTR,
  input  logic [XLEN-1:0] PC,
  input  logic            INSTR_VALID,
  output logic            INSTR_READY,
  input  logic            STALL,
  input  logic            WB_EN,
  input  logic [4:0]      WB_RD,
  input  logic [XLEN-1:0] WB_DATA,
  output logic [3:0]      OP_VAL,
  output logic [XLEN-1:0] A,
  output logic [XLEN-1:0] B,
  output logic [4:0]      RD,
  output logic            RD_WE,
  output logic            ILLEGAL
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b1011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

  logic [XLEN-1:0] regs [NREGS];

  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  logic       f7_zero, f7_alt, is_shift;
  logic signed [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u, rs1_val, rs2_val;

  assign opcode   = INSTR[6:0];
  assign rd       = INSTR[11:7];
  assign f3       = INSTR[14:12];
  assign rs1      = INSTR[19:15];
  assign rs2      = INSTR[24:20];
  assign f7_zero  = (INSTR[31:25] == 7'b0000000);
  assign f7_alt   = (INSTR[31:25] == 7'b0100000);
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);
  assign imm_i    = {{(XLEN-12){INSTR[31]}}, INSTR[31:20]};
  assign imm_u    = {INSTR[31:12], 12'b0};

`ifdef DECODE_WB_BYPASS_EN
  assign rs1_val = (rs1 == 5'd0) ? '0 : (WB_EN && WB_RD == rs1) ? WB_DATA : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : (WB_EN && WB_RD == rs2) ? WB_DATA : regs[rs2];
`else
  assign rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2];
`endif

  // p0: combinational decode of the offered instruction
  logic            vld_p0, dec_ok;
  logic [3:0]      dec_op;
  logic [XLEN-1:0] dec_a, dec_b;

  assign vld_p0      = INSTR_VALID && !STALL;
  assign INSTR_READY = !STALL;

  always_comb begin
    dec_ok = 1'b0;
    dec_op = 4'b0000;
    dec_a  = rs1_val;
    dec_b  = rs2_val;
    case (opcode)
      OPC_OP: begin
        dec_ok = f7_zero || (f7_alt && (f3 == 3'b000 || f3 == 3'b101));
        dec_op = alu_op(f3, f7_alt);
        if (is_shift) dec_b = {{(XLEN-5){1'b0}}, rs2_val[4:0]};
      end
      OPC_IMM: begin
        // Only shifts carry funct7; elsewhere those bits are immediate.
        dec_ok = (f3 == 3'b001) ? f7_zero :
                 (f3 == 3'b101) ? (f7_zero || f7_alt) : 1'b1;
        dec_op = alu_op(f3, f7_alt && (f3 == 3'b101));
        dec_b  = is_shift ? {{(XLEN-5){1'b0}}, rs2} : imm_i;
      end
      OPC_LUI: begin
        dec_ok = 1'b1;
        dec_op = ALU_ADD;
        dec_a  = '0;
        dec_b  = imm_u;
      end
      OPC_AUIPC: begin
        dec_ok = 1'b1;
        dec_op = ALU_ADD;
        dec_a  = PC;
        dec_b  = imm_u;
      end
      default: dec_ok = 1'b0;
    endcase
  end

  // p1: registered issue bundle seen by the ALU
  logic [3:0]      op_p1;
  logic [XLEN-1:0] a_p1, b_p1;
  logic [4:0]      rd_p1;
  logic            rd_we_p1, ill_p1;

  always_ff @(posedge CK_REF or negedge RST_N) begin
    if (!RST_N) begin
      op_p1    <= 4'b0000;
      a_p1     <= '0;
      b_p1     <= '0;
      rd_p1    <= 5'd0;
      rd_we_p1 <= 1'b0;
      ill_p1   <= 1'b0;
    end else if (!STALL) begin
      op_p1    <= 4'b0000;
      rd_we_p1 <= 1'b0;
      ill_p1   <= 1'b0;
      if (vld_p0) begin
        if (dec_ok) begin
          op_p1    <= dec_op;
          a_p1     <= dec_a;
          b_p1     <= dec_b;
          rd_p1    <= rd;
          rd_we_p1 <= (rd != 5'd0);
        end else begin
          ill_p1   <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CK_REF or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (WB_EN && WB_RD != 5'd0) begin
      regs[WB_RD] <= WB_DATA;
    end
  end

  assign OP_VAL  = op_p1;
  assign A       = a_p1;
  assign B       = b_p1;
  assign RD      = rd_p1;
  assign RD_WE   = rd_we_p1;
  assign ILLEGAL = ill_p1;

endmodule

// File: tb/tb_decode_stage.sv
// Directed plus randomized bench for decode_stage against a table-driven reference model.
module tb_decode_stage;

  logic        CK_REF = 1'b0;
  logic        RST_N  = 1'b1;
  logic [31:0] INSTR  = 32'h0;
  logic [31:0] PC     = 32'h0;
  logic        INSTR_VALID = 1'b0;
  logic        INSTR_READY;
  logic        STALL  = 1'b0;
  logic        WB_EN  = 1'b0;
  logic [4:0]  WB_RD  = 5'd0;
  logic [31:0] WB_DATA = 32'h0;
  logic [3:0]  OP_VAL;
  logic [31:0] A, B;
  logic [4:0]  RD;
  logic        RD_WE, ILLEGAL;

  decode_stage dut (
    .CK_REF(CK_REF), .RST_N(RST_N), .INSTR(INSTR), .PC(PC),
    .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY), .STALL(STALL),
    .WB_EN(WB_EN), .WB_RD(WB_RD), .WB_DATA(WB_DATA),
    .OP_VAL(OP_VAL), .A(A), .B(B), .RD(RD), .RD_WE(RD_WE), .ILLEGAL(ILLEGAL)
  );

  always #5 CK_REF = ~CK_REF;

  // {funct7, funct3, op code} for every legal register-register operation
  localparam logic [13:0] OP_TAB [10] = '{
    {7'h00, 3'd0, 4'h1}, {7'h20, 3'd0, 4'h2}, {7'h00, 3'd1, 4'h7},
    {7'h00, 3'd2, 4'h3}, {7'h00, 3'd3, 4'hB}, {7'h00, 3'd4, 4'h6},
    {7'h00, 3'd5, 4'h8}, {7'h20, 3'd5, 4'h9}, {7'h00, 3'd6, 4'h5},
    {7'h00, 3'd7, 4'h4}
  };

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [31:0] ref_regs [32];
  logic [3:0]  m_op;
  logic [31:0] m_a, m_b;
  logic [4:0]  m_rd;
  logic        m_we, m_ill;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) ref_regs[i] = 32'h0;
    m_op = 4'h0; m_a = 32'h0; m_b = 32'h0; m_rd = 5'd0; m_we = 1'b0; m_ill = 1'b0;
  endtask

  function automatic void ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                     input logic [31:0] r1, input logic [31:0] r2,
                                     output logic ok, output logic [3:0] op,
                                     output logic [31:0] a, output logic [31:0] b);
    logic [6:0] opc;
    logic [6:0] key7;
    logic       shift;
    opc = ins[6:0];
    ok = 1'b0; op = 4'h0; a = 32'h0; b = 32'h0;
    if (opc == 7'h33 || opc == 7'h13) begin
      key7  = ins[31:25];
      shift = (ins[13:12] == 2'b01);
      if (opc == 7'h13 && !shift) key7 = 7'h00;
      for (int k = 0; k < 10; k++)
        if (OP_TAB[k][13:4] == {key7, ins[14:12]}) begin
          ok = 1'b1;
          op = OP_TAB[k][3:0];
        end
      a = r1;
      if (opc == 7'h33) b = shift ? (r2 % 32) : r2;
      else              b = shift ? 32'(ins[24:20]) : 32'($signed(ins[31:20]));
    end else if (opc == 7'h37 || opc == 7'h17) begin
      ok = 1'b1;
      op = 4'h1;
      a  = (opc == 7'h17) ? pc : 32'h0;
      b  = {ins[31:12], 12'h000};
    end
  endfunction

  task automatic cycle();
    logic [31:0] r1, r2, a, b;
    logic        ok;
    logic [3:0]  op;
    r1 = ref_regs[INSTR[19:15]];
    r2 = ref_regs[INSTR[24:20]];
`ifdef DECODE_WB_BYPASS_EN
    if (WB_EN && WB_RD != 5'd0 && WB_RD == INSTR[19:15]) r1 = WB_DATA;
    if (WB_EN && WB_RD != 5'd0 && WB_RD == INSTR[24:20]) r2 = WB_DATA;
`endif
    ref_decode(INSTR, PC, r1, r2, ok, op, a, b);
    if (!STALL) begin
      m_op = 4'h0; m_we = 1'b0; m_ill = 1'b0;
      if (INSTR_VALID) begin
        if (ok) begin
          m_op = op; m_a = a; m_b = b; m_rd = INSTR[11:7]; m_we = (INSTR[11:7] != 5'd0);
        end else begin
          m_ill = 1'b1;
        end
      end
    end
    if (WB_EN && WB_RD != 5'd0) ref_regs[WB_RD] = WB_DATA;
    @(posedge CK_REF);
    #1;
    chk("op_val", 32'(OP_VAL), 32'(m_op));
    chk("a", A, m_a);
    chk("b", B, m_b);
    chk("rd", 32'(RD), 32'(m_rd));
    chk("rd_we", 32'(RD_WE), 32'(m_we));
    chk("illegal", 32'(ILLEGAL), 32'(m_ill));
    chk("instr_ready", 32'(INSTR_READY), 32'(!STALL));
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_op"}, 32'(OP_VAL), 32'h0);
    chk({tag, "_a"}, A, 32'h0);
    chk({tag, "_b"}, B, 32'h0);
    chk({tag, "_rd"}, 32'(RD), 32'h0);
    chk({tag, "_we"}, 32'(RD_WE), 32'h0);
    chk({tag, "_ill"}, 32'(ILLEGAL), 32'h0);
  endtask

  task automatic read_all_zero();
    for (int i = 0; i < 32; i++) begin
      INSTR = {7'h00, 5'(31 - i), 5'(i), 3'd6, 5'd0, 7'h33};
      INSTR_VALID = 1'b1;
      cycle();
      chk("rf_zero_a", A, 32'h0);
      chk("rf_zero_b", B, 32'h0);
    end
    INSTR_VALID = 1'b0;
  endtask

  function automatic logic [31:0] gen_instr();
    logic [4:0]  r_d, r_1, r_2;
    logic [2:0]  f;
    logic [11:0] imm;
    logic [6:0]  f7;
    int          kind;
    r_d = 5'($urandom_range(0, 7));
    r_1 = 5'($urandom_range(0, 7));
    r_2 = 5'($urandom_range(0, 7));
    f   = 3'($urandom_range(0, 7));
    imm = 12'($urandom);
    kind = $urandom_range(0, 9);
    f7 = (f == 3'd0 || f == 3'd5) && $urandom_range(0, 1) == 1 ? 7'h20 : 7'h00;
    case (kind)
      0, 1, 2: gen_instr = {f7, r_2, r_1, f, r_d, 7'h33};
      3, 4: begin
        if (f == 3'd1)      imm[11:5] = 7'h00;
        else if (f == 3'd5) imm[11:5] = f7;
        gen_instr = {imm, r_1, f, r_d, 7'h13};
      end
      5:       gen_instr = {20'($urandom), r_d, 7'h37};
      6:       gen_instr = {20'($urandom), r_d, 7'h17};
      7:       gen_instr = {7'($urandom), r_2, r_1, f, r_d, 7'h33};
      8:       gen_instr = {7'($urandom), r_2, r_1, (f[0] ? 3'd1 : 3'd5), r_d, 7'h13};
      default: gen_instr = $urandom;
    endcase
  endfunction

  initial begin
    model_reset();
    // asynchronous reset, seen before any clock edge
    #2 RST_N = 1'b0;
    #1 check_zero_outputs("reset");
    @(negedge CK_REF);
    @(negedge CK_REF);
    RST_N = 1'b1;

    cycle();
    chk("idle_op", 32'(OP_VAL), 32'h0);
    chk("idle_ill", 32'(ILLEGAL), 32'h0);
    read_all_zero();

    WB_EN = 1'b1; WB_RD = 5'd1; WB_DATA = 32'd5;
    cycle();
    WB_RD = 5'd2; WB_DATA = 32'd3;
    cycle();
    WB_EN = 1'b0;

    INSTR = 32'h002081B3; INSTR_VALID = 1'b1;
    cycle();
    chk("add_op", 32'(OP_VAL), 32'h1);
    chk("add_a", A, 32'd5);
    chk("add_b", B, 32'd3);
    chk("add_rd", 32'(RD), 32'd3);
    chk("add_we", 32'(RD_WE), 32'd1);

    INSTR = 32'h41F0D213;
    cycle();
    chk("srai_op", 32'(OP_VAL), 32'h9);
    chk("srai_b", B, 32'd31);

    INSTR = 32'hFFF00293;
    cycle();
    chk("addi_op", 32'(OP_VAL), 32'h1);
    chk("addi_a", A, 32'h0);
    chk("addi_b", B, 32'hFFFFFFFF);

    INSTR = 32'h12345317; PC = 32'h100;
    cycle();
    chk("auipc_op", 32'(OP_VAL), 32'h1);
    chk("auipc_a", A, 32'h100);
    chk("auipc_b", B, 32'h12345000);
    chk("auipc_rd", 32'(RD), 32'd6);

    STALL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      INSTR = {7'h00, 5'd2, 5'd1, 3'(i), 5'(9 + i), 7'h33};
      cycle();
      chk("stall_ready", 32'(INSTR_READY), 32'h0);
      chk("stall_op", 32'(OP_VAL), 32'h1);
      chk("stall_a", A, 32'h100);
      chk("stall_b", B, 32'h12345000);
    end
    STALL = 1'b0;
    INSTR = 32'h40208433;
    cycle();
    chk("sub_op", 32'(OP_VAL), 32'h2);
    chk("sub_a", A, 32'd5);
    chk("sub_b", B, 32'd3);
    chk("sub_rd", 32'(RD), 32'd8);

    INSTR = 32'h0000A183;
    cycle();
    chk("load_op", 32'(OP_VAL), 32'h0);
    chk("load_we", 32'(RD_WE), 32'h0);
    chk("load_ill", 32'(ILLEGAL), 32'h1);
    INSTR_VALID = 1'b0;
    cycle();
    chk("load_ill_clear", 32'(ILLEGAL), 32'h0);

    WB_EN = 1'b1; WB_RD = 5'd1; WB_DATA = 32'd9;
    INSTR = 32'h001081B3; INSTR_VALID = 1'b1;
    cycle();
    WB_EN = 1'b0;
`ifdef DECODE_WB_BYPASS_EN
    chk("waw_a", A, 32'd9);
    chk("waw_b", B, 32'd9);
`else
    chk("waw_a", A, 32'd5);
    chk("waw_b", B, 32'd5);
`endif

    // reset arriving while a held instruction is pending
    STALL = 1'b1; INSTR = 32'h002081B3;
    cycle();
    #2 RST_N = 1'b0;
    #1 model_reset();
    check_zero_outputs("midstall_reset");
    @(negedge CK_REF);
    RST_N = 1'b1; STALL = 1'b0; INSTR_VALID = 1'b0;
    read_all_zero();

    for (int n = 0; n < 400; n++) begin
      STALL       = ($urandom_range(0, 4) == 0);
      INSTR_VALID = ($urandom_range(0, 3) != 0);
      INSTR       = gen_instr();
      PC          = $urandom & 32'hFFFF_FFFC;
      WB_EN       = $urandom_range(0, 1) == 1;
      WB_RD       = 5'($urandom_range(0, 7));
      WB_DATA     = $urandom;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- RV32I decode stage sitting directly upstream of the ALU.
- Accepts a fetched instruction and its PC over a valid/ready handshake, reads rs1/rs2 from an internal 32x32 register file, and builds operands.
- Drives a registered OP_VAL/A/B/RD bundle that the ALU samples on the next edge.
- Also owns the register-file write port used by writeback.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- NREGS, 32, number of architectural registers; x0 is hardwired to zero.

Ports:
- CK_REF  in  1  rising-edge clock
- RST_N  in  1  reset, asynchronous, active-low
- INSTR  in  32  instruction word from fetch
- PC  in  32  address of INSTR
- INSTR_VALID  in  1  INSTR/PC are valid this cycle
- INSTR_READY  out  1  stage can accept; equals !STALL
- STALL  in  1  hazard/downstream hold request
- WB_EN  in  1  register-file write enable
- WB_RD  in  5  write address
- WB_DATA  in  32  write data
- OP_VAL  out  4  ALU operation code; 0000 = bubble
- A  out  32  ALU operand A
- B  out  32  ALU operand B
- RD  out  5  destination register, carried to writeback
- RD_WE  out  1  destination write enable, carried to writeback
- ILLEGAL  out  1  one-cycle pulse on an unsupported encoding

Behaviour:
- Reset: OP_VAL=0000, A=0, B=0, RD=0, RD_WE=0, ILLEGAL=0. All 31 writable registers clear to 0. Reset takes effect immediately, including mid-stall; the in-flight instruction is discarded.
- Accept: an instruction is accepted when INSTR_VALID && !STALL at a rising edge. Decoded outputs appear registered after that same edge (1-cycle latency). The ALU captures them on the following edge.
- STALL=1: all outputs hold their values. INSTR is not accepted. Register-file writes still occur.
- No accept and STALL=0: issue a bubble. OP_VAL=0000, RD_WE=0, ILLEGAL=0. A, B and RD hold their last values (don't-care).
- OP_VAL encoding:
  - ADD=0001, SUB=0010, SLT=0011, SLTU=1011
  - AND=0100, OR=0101, XOR=0110
  - SLL=0111, SRL=1000, SRA=1001
- Opcode 0110011 (OP):
  - A=rs1, B=rs2.
  - funct7 must be 0000000 for all funct3, or 0100000 only with funct3 000 (SUB) or 101 (SRA).
  - Shifts: B = {27'b0, rs2[4:0]}.
- Opcode 0010011 (OP-IMM):
  - A=rs1, B = sign-extended imm[11:0].
  - ADDI, SLTI, SLTIU, XORI, ORI and ANDI map to the matching OP_VAL.
  - SLLI/SRLI/SRAI: B = {27'b0, shamt}. funct7 is checked as for OP.
  - SLTIU compares against the sign-extended immediate, treated as unsigned.
- Opcode 0110111 (LUI): OP_VAL=ADD, A=0, B={imm[31:12],12'b0}.
- Opcode 0010111 (AUIPC): OP_VAL=ADD, A=PC, B={imm[31:12],12'b0}.
- Destination fields for legal instructions: RD=INSTR[11:7]. RD_WE=1 unless RD==0.
- Any other opcode or illegal funct7 combination: issue a bubble, set RD_WE=0, and assert ILLEGAL for exactly one cycle.
- Register file:
  - Two asynchronous read ports and one synchronous write port at the rising edge.
  - Writes with WB_RD==0 are ignored. Reading x0 always returns 0.
- Write-after-read in the same edge: when WB_EN and accept coincide, register contents update. Operand source is described under Optional Feature.

Optional Feature:
- Macro: DECODE_WB_BYPASS_EN.
- Defined: when WB_EN && WB_RD!=0 && WB_RD==rs1 (or rs2) in the accept cycle, the operand takes WB_DATA. This applies per port independently, including both ports hitting the same register.
- Undefined: operands always come from the stored array (the old value). Software or a hazard unit must space dependent instructions by at least one cycle.

Test Plan:
- Reset, then idle with INSTR_VALID=0 -> OP_VAL=0000, RD_WE=0, ILLEGAL=0, and every register reads 0.
- Write x1=5 and x2=3 via WB. Then issue ADD x3,x1,x2 (0x002081B3) -> next cycle OP_VAL=0001, A=5, B=3, RD=3, RD_WE=1.
- SRAI x4,x1,31 (0x41F0D213) -> OP_VAL=1001, B=31. Also ADDI x5,x0,-1 -> OP_VAL=0001, A=0, B=0xFFFFFFFF.
- AUIPC x6,0x12345 with PC=0x100 -> OP_VAL=0001, A=0x100, B=0x12345000, RD=6.
- Issue an instruction with STALL=1 for 3 cycles while INSTR changes -> outputs frozen and INSTR_READY=0. Only the instruction present when STALL drops is decoded.
- Opcode 0000011 (load) -> OP_VAL=0000, RD_WE=0, ILLEGAL=1 for one cycle. Then with DECODE_WB_BYPASS_EN defined, issue WB x1=9 and ADD x3,x1,x1 in the same cycle -> A=9, B=9; with the macro undefined -> A=5, B=5.
